// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control sequencer: walks each instruction through
// fetch / decode / execute / memory / writeback and drives the datapath
// enables and mux selects as a pure function of the current state.
//
// Memory handshake: mem_req is the valid; mem_ready is the ready. A transfer
// completes on the rising edge where both are high. While mem_req is high and
// mem_ready is low, the address select and mem_we hold steady. mem_ready is
// ignored whenever mem_req is low.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [3:0] alu_control,
  output logic       halted,
  output logic [3:0] o_state
);

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_LUI, S_AUIPC, S_ALUWB, S_BRANCH, S_JALRADR, S_JAL,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b1001;

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] w_alu_dec;
  logic       w_taken;

  assign o_state = r_state;

  // State register; reset is asynchronous so mem_req drops mid-transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_RESET;
    else       r_state <= w_next_state;
  end

  // ALU operation for R/I-type execute; SUB only exists for register form.
  always_comb begin
    w_alu_dec = ALU_ADD;
    case (funct3)
      3'b000: w_alu_dec = (funct7b5 && (r_state == S_EXECR)) ? ALU_SUB : ALU_ADD;
      3'b001: w_alu_dec = ALU_SLL;
      3'b010: w_alu_dec = ALU_SLT;
      3'b011: w_alu_dec = ALU_SLTU;
      3'b100: w_alu_dec = ALU_XOR;
      3'b101: w_alu_dec = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110: w_alu_dec = ALU_OR;
      3'b111: w_alu_dec = ALU_AND;
      default: w_alu_dec = ALU_ADD;
    endcase
  end

  // Branch taken condition from the ALU flags of rs1 - rs2.
  always_comb begin
    w_taken = 1'b0;
    case (funct3)
      3'b000: w_taken = zero;
      3'b001: w_taken = !zero;
      3'b100: w_taken = lt;
      3'b101: w_taken = !lt;
      3'b110: w_taken = ltu;
      3'b111: w_taken = !ltu;
      default: w_taken = 1'b0;
    endcase
  end

  // Next-state and datapath control outputs, all zero unless a state sets them.
  always_comb begin
    w_next_state = r_state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    adr_src      = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    reg_write    = 1'b0;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    result_src   = 2'b00;
    alu_control  = ALU_ADD;
    halted       = 1'b0;
    case (r_state)
      S_RESET: w_next_state = S_FETCH;
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_write     = 1'b1;
          pc_write     = 1'b1;
          w_next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        // Precompute OldPC + imm (branch / JAL target) into ALUOut.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: w_next_state = S_MEMADR;
          OP_RTYPE:          w_next_state = S_EXECR;
          OP_ITYPE:          w_next_state = S_EXECI;
          OP_BRANCH:         w_next_state = S_BRANCH;
          OP_JAL:            w_next_state = S_JAL;
          OP_JALR:           w_next_state = S_JALRADR;
          OP_LUI:            w_next_state = S_LUI;
          OP_AUIPC:          w_next_state = S_AUIPC;
          default:           w_next_state = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a    = 2'b10;
        alu_src_b    = 2'b01;
        w_next_state = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) w_next_state = S_MEMWB;
      end
      S_MEMWB: begin
        result_src   = 2'b01;
        reg_write    = 1'b1;
        w_next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) w_next_state = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a    = 2'b10;
        alu_control  = w_alu_dec;
        w_next_state = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a    = 2'b10;
        alu_src_b    = 2'b01;
        alu_control  = w_alu_dec;
        w_next_state = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a    = 2'b11;
        alu_src_b    = 2'b01;
        w_next_state = S_ALUWB;
      end
      S_AUIPC: begin
        alu_src_a    = 2'b01;
        alu_src_b    = 2'b01;
        w_next_state = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write    = 1'b1;
        w_next_state = S_FETCH;
      end
      S_BRANCH: begin
        // ALUOut still holds the target computed in DECODE.
        alu_src_a    = 2'b10;
        alu_control  = ALU_SUB;
        pc_write     = w_taken;
        w_next_state = S_FETCH;
      end
      S_JALRADR: begin
        alu_src_a    = 2'b10;
        alu_src_b    = 2'b01;
        w_next_state = S_JAL;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms OldPC + 4 for rd.
        alu_src_a    = 2'b01;
        alu_src_b    = 2'b10;
        pc_write     = 1'b1;
        w_next_state = S_ALUWB;
      end
      S_TRAP: halted = 1'b1;
      default: w_next_state = S_RESET;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: an instruction-level model expands each
// instruction into its expected per-cycle control vectors, and a single
// compare process checks the DUT against them on every falling edge.
module tb_multicycle_control;

  localparam int W = 17;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ADD = 4'd0;
  localparam logic [3:0] SUB = 4'd1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0, lt = 1'b0, ltu = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, halted;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [3:0] alu_control;
  logic [3:0] o_state;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .lt(lt), .ltu(ltu),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .alu_control(alu_control), .halted(halted),
    .o_state(o_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] act;
  logic [W-1:0] e_cmp;
  int n_vec = 0;
  int n_err = 0;

  assign act = {halted, mem_req, mem_we, adr_src, ir_write, pc_write,
                reg_write, alu_src_a, alu_src_b, result_src, alu_control};

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e_cmp = exp_q.pop_front();
      n_vec++;
      if (act !== e_cmp) begin
        n_err++;
        $display("FAIL cycle_outputs t=%0t got=%05h want=%05h", $time, act, e_cmp);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] v(input logic halt, req, we, adr, irw, pcw, rw,
                                     input logic [1:0] a, b, rs, input logic [3:0] alu);
    return {halt, req, we, adr, irw, pcw, rw, a, b, rs, alu};
  endfunction

  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic f7, input logic is_r);
    logic [3:0] tab [8];
    logic [3:0] r;
    tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    r = tab[f3];
    if (f7 && f3 == 3'd5) r = 4'd7;
    if (is_r && f7 && f3 == 3'd0) r = 4'd1;
    return r;
  endfunction

  function automatic logic taken_of(input logic [2:0] f3, input logic [31:0] x, y);
    case (f3)
      3'd0: return x == y;
      3'd1: return x != y;
      3'd4: return $signed(x) < $signed(y);
      3'd5: return $signed(x) >= $signed(y);
      3'd6: return x < y;
      3'd7: return x >= y;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // ---------------- driver ----------------
  logic [6:0] cur_op = 7'd0;
  logic [2:0] cur_f3 = 3'd0;
  logic       cur_f7 = 1'b0;
  logic       cur_z = 1'b0, cur_lt = 1'b0, cur_ltu = 1'b0;

  task automatic run_cycle(input logic mr, input logic [W-1:0] e);
    @(posedge clk);
    #1;
    mem_ready = mr;
    opcode    = cur_op;
    funct3    = cur_f3;
    funct7b5  = cur_f7;
    zero      = cur_z;
    lt        = cur_lt;
    ltu       = cur_ltu;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.push_back('0);
    repeat (n - 1) begin
      @(posedge clk);
      #1;
      exp_q.push_back('0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    mem_ready = rb();
    exp_q.push_back('0);
  endtask

  // Expands one instruction into expected cycles; ncyc is its length.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input int fw, input int mw, input logic [31:0] x, y,
                           output int ncyc);
    logic [W-1:0] mv;
    ncyc = 0;
    repeat (fw) begin
      run_cycle(1'b0, v(0,1,0,0,0,0,0,2'b00,2'b10,2'b10,ADD)); ncyc++;
    end
    run_cycle(1'b1, v(0,1,0,0,1,1,0,2'b00,2'b10,2'b10,ADD)); ncyc++;
    cur_op = op; cur_f3 = f3; cur_f7 = f7;
    cur_z = (x == y); cur_lt = ($signed(x) < $signed(y)); cur_ltu = (x < y);
    run_cycle(rb(), v(0,0,0,0,0,0,0,2'b01,2'b01,2'b00,ADD)); ncyc++;
    case (op)
      OP_LOAD, OP_STORE: begin
        run_cycle(rb(), v(0,0,0,0,0,0,0,2'b10,2'b01,2'b00,ADD)); ncyc++;
        mv = v(0,1,op == OP_STORE,1,0,0,0,2'b00,2'b00,2'b00,ADD);
        repeat (mw) begin run_cycle(1'b0, mv); ncyc++; end
        run_cycle(1'b1, mv); ncyc++;
        if (op == OP_LOAD) begin
          run_cycle(rb(), v(0,0,0,0,0,0,1,2'b00,2'b00,2'b01,ADD)); ncyc++;
        end
      end
      OP_RTYPE, OP_ITYPE, OP_LUI, OP_AUIPC: begin
        if (op == OP_RTYPE)
          run_cycle(rb(), v(0,0,0,0,0,0,0,2'b10,2'b00,2'b00,alu_of(f3, f7, 1'b1)));
        else if (op == OP_ITYPE)
          run_cycle(rb(), v(0,0,0,0,0,0,0,2'b10,2'b01,2'b00,alu_of(f3, f7, 1'b0)));
        else if (op == OP_LUI)
          run_cycle(rb(), v(0,0,0,0,0,0,0,2'b11,2'b01,2'b00,ADD));
        else
          run_cycle(rb(), v(0,0,0,0,0,0,0,2'b01,2'b01,2'b00,ADD));
        ncyc++;
        run_cycle(rb(), v(0,0,0,0,0,0,1,2'b00,2'b00,2'b00,ADD)); ncyc++;
      end
      OP_BRANCH: begin
        run_cycle(rb(), v(0,0,0,0,0,taken_of(f3, x, y),0,2'b10,2'b00,2'b00,SUB)); ncyc++;
      end
      OP_JAL, OP_JALR: begin
        if (op == OP_JALR) begin
          run_cycle(rb(), v(0,0,0,0,0,0,0,2'b10,2'b01,2'b00,ADD)); ncyc++;
        end
        run_cycle(rb(), v(0,0,0,0,0,1,0,2'b01,2'b10,2'b00,ADD)); ncyc++;
        run_cycle(rb(), v(0,0,0,0,0,0,1,2'b00,2'b00,2'b00,ADD)); ncyc++;
      end
      default: begin
        repeat (12) begin
          run_cycle(rb(), v(1,0,0,0,0,0,0,2'b00,2'b00,2'b00,ADD)); ncyc++;
        end
      end
    endcase
  endtask

  // ---------------- stimulus ----------------
  logic [6:0] legal [9];
  int n;
  logic [31:0] rx, ry;

  initial begin
    legal = '{OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH,
              OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

    // Model pins: decode tables against hand-worked values.
    chk("alu_sub_r", 32'(alu_of(3'd0, 1'b1, 1'b1)), 32'h1);
    chk("alu_srai", 32'(alu_of(3'd5, 1'b1, 1'b0)), 32'h7);
    chk("alu_addi_f7", 32'(alu_of(3'd0, 1'b1, 1'b0)), 32'h0);
    chk("bne_ne", 32'(taken_of(3'd1, 32'd5, 32'd7)), 32'h1);
    chk("bne_eq", 32'(taken_of(3'd1, 32'd5, 32'd5)), 32'h0);

    // Reset, then SUB with zero memory wait.
    do_reset(2);
    run_instr(OP_RTYPE, 3'd0, 1'b1, 0, 0, 32'd1, 32'd2, n);
    chk("cpi_rtype", n, 4);
    run_instr(OP_LOAD, 3'd2, 1'b0, 0, 3, 32'd1, 32'd2, n);
    chk("cpi_load_wait3", n, 8);
    run_instr(OP_BRANCH, 3'd1, 1'b0, 0, 0, 32'd3, 32'd9, n);
    chk("cpi_bne_taken", n, 3);
    run_instr(OP_BRANCH, 3'd1, 1'b0, 0, 0, 32'd9, 32'd9, n);
    chk("cpi_bne_not", n, 3);
    run_instr(OP_JALR, 3'd0, 1'b0, 0, 0, 32'd0, 32'd0, n);
    chk("cpi_jalr", n, 5);
    run_instr(OP_JAL, 3'd0, 1'b0, 0, 0, 32'd0, 32'd0, n);
    chk("cpi_jal", n, 4);
    run_instr(OP_STORE, 3'd2, 1'b0, 0, 0, 32'd0, 32'd0, n);
    chk("cpi_store", n, 4);
    run_instr(OP_ITYPE, 3'd5, 1'b1, 0, 0, 32'd0, 32'd0, n);
    run_instr(OP_ITYPE, 3'd0, 1'b1, 0, 0, 32'd0, 32'd0, n);

    // Randomized instruction stream with random memory waits.
    for (int i = 0; i < 250; i++) begin
      rx = $urandom;
      ry = ($urandom_range(0, 3) == 0) ? rx : $urandom;
      if ($urandom_range(0, 3) == 0) ry = rx ^ 32'h8000_0000;
      run_instr(legal[$urandom_range(0, 8)], 3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)), $urandom_range(0, 3),
                $urandom_range(0, 3), rx, ry, n);
    end

    // Illegal opcode traps and stays halted until reset.
    run_instr(7'b1111111, 3'd0, 1'b0, 1, 0, 32'd0, 32'd0, n);
    @(negedge clk);
    #1;
    chk("trap_halted", 32'(halted), 32'h1);
    do_reset(2);

    // Reset asserted mid-way through a stalled store.
    run_cycle(1'b1, v(0,1,0,0,1,1,0,2'b00,2'b10,2'b10,ADD));
    cur_op = OP_STORE; cur_f3 = 3'd2; cur_f7 = 1'b0;
    run_cycle(rb(), v(0,0,0,0,0,0,0,2'b01,2'b01,2'b00,ADD));
    run_cycle(rb(), v(0,0,0,0,0,0,0,2'b10,2'b01,2'b00,ADD));
    run_cycle(1'b0, v(0,1,1,1,0,0,0,2'b00,2'b00,2'b00,ADD));
    run_cycle(1'b0, v(0,1,1,1,0,0,0,2'b00,2'b00,2'b00,ADD));
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("reset_async_outputs", 32'(act), 32'h0);
    chk("reset_async_memreq", 32'(mem_req), 32'h0);
    do_reset(2);
    run_instr(OP_LUI, 3'd0, 1'b0, 2, 0, 32'd0, 32'd0, n);
    chk("cpi_lui_fwait2", n, 6);

    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle RV32I control sequencer for the CPU core. It steps each instruction through fetch, decode, execute, memory and writeback states. It drives the shared ALU, PC, instruction-register and memory-port enables, and selects the ALU operand and result muxes. The immediate generator feeds the ALU B-mux. The single memory port uses a req/ready handshake, so it can take a variable number of cycles.

## Interface
- No parameters.
- `clk`  in  1  core clock, rising edge.
- `reset`  in  1  asynchronous, active-high; forces state RESET.
- `opcode`  in  7  instr[6:0] from the instruction register.
- `funct3`  in  3  instr[14:12].
- `funct7b5`  in  1  instr[30].
- `zero`, `lt`, `ltu`  in  1 each  ALU flags for rs1−rs2: equal, signed less-than, unsigned less-than.
- `mem_ready`  in  1  memory completes the current request this cycle.
- `mem_req`  out  1  memory request valid.
- `mem_we`  out  1  write request; only meaningful when `mem_req`=1.
- `adr_src`  out  1  0 = address from PC, 1 = address from ALUOut.
- `ir_write`  out  1  latch the instruction register and OldPC.
- `pc_write`  out  1  PC <= Result.
- `reg_write`  out  1  register file writes Result to rd.
- `alu_src_a`  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero.
- `alu_src_b`  out  2  00 rs2, 01 ImmExt, 10 constant 4.
- `result_src`  out  2  00 ALUOut, 01 memory data, 10 ALU result.
- `alu_control`  out  4  0000 ADD, 0001 SUB, 0010 SLL, 0011 SLT, 0100 SLTU, 0101 XOR, 0110 SRL, 0111 SRA, 1000 OR, 1001 AND.
- `halted`  out  1  illegal opcode trapped.

## Operation
- All outputs are 0 in any state or cycle not listed below.
- RESET: all outputs 0; next state FETCH.
- FETCH:
  - Drives `mem_req`=1, `adr_src`=0, `alu_src_a`=00, `alu_src_b`=10, ADD, `result_src`=10.
  - In the cycle `mem_ready`=1: `ir_write`=1, `pc_write`=1, go to DECODE. Otherwise hold in FETCH.
- DECODE: `alu_src_a`=01, `alu_src_b`=01, ADD. This precomputes the branch/JAL target into ALUOut. Dispatch on `opcode`:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALRADR
  - 0110111 → LUI
  - 0010111 → AUIPC
  - any other opcode → TRAP
- MEMADR: `alu_src_a`=10, `alu_src_b`=01, ADD. Load → MEMREAD; store → MEMWRITE.
- MEMREAD: `mem_req`=1, `adr_src`=1. Wait for `mem_ready`, then MEMWB.
- MEMWB: `result_src`=01, `reg_write`=1 → FETCH.
- MEMWRITE: `mem_req`=1, `mem_we`=1, `adr_src`=1. Wait for `mem_ready`, then FETCH.
- EXECR: `alu_src_a`=10, `alu_src_b`=00. ALU decode from funct3:
  - 000: ADD, or SUB if `funct7b5`
  - 001: SLL
  - 010: SLT
  - 011: SLTU
  - 100: XOR
  - 101: SRL, or SRA if `funct7b5`
  - 110: OR
  - 111: AND
  - Next state ALUWB.
- EXECI: as EXECR but `alu_src_b`=01. funct3=000 is always ADD (no SUB). funct3=101 uses `funct7b5` for SRA. Next state ALUWB.
- LUI: `alu_src_a`=11, `alu_src_b`=01, ADD → ALUWB.
- AUIPC: `alu_src_a`=01, `alu_src_b`=01, ADD → ALUWB.
- ALUWB: `result_src`=00, `reg_write`=1 → FETCH.
- BRANCH:
  - `alu_src_a`=10, `alu_src_b`=00, SUB, `result_src`=00.
  - Taken condition by funct3: 000 `zero`; 001 !`zero`; 100 `lt`; 101 !`lt`; 110 `ltu`; 111 !`ltu`; 010/011 never taken.
  - `pc_write` equals the taken condition. Next state FETCH.
- JALRADR: `alu_src_a`=10, `alu_src_b`=01, ADD → JAL. The datapath clears bit 0 of the target.
- JAL: `alu_src_a`=01, `alu_src_b`=10, ADD, `result_src`=00, `pc_write`=1 → ALUWB. ALUOut now holds PC+4 for rd.
- TRAP: `halted`=1, all other outputs 0. Stays in TRAP until `reset`.

## Timing
- State register updates on `posedge clk`. Asserting `reset` sends it to RESET asynchronously, including mid-transfer; `mem_req` drops immediately.
- Outputs are combinational from state. `ir_write` and `pc_write` in FETCH additionally depend on `mem_ready`.
- `mem_req` is held high until `mem_ready` is sampled high. Address and `mem_we` are stable while waiting.
- `mem_ready` is ignored when `mem_req`=0.
- Cycles per instruction with zero memory wait; each memory wait cycle adds 1:
  - load: 5
  - store: 4
  - R-type, I-type, LUI, AUIPC: 4
  - branch: 3
  - JAL: 4
  - JALR: 5
- First FETCH is the cycle after `reset` deasserts.

## Test plan
- Reset, then `mem_ready`=1 always, opcode 0110011 funct3 000 `funct7b5`=1 → states RESET, FETCH, DECODE, EXECR (`alu_control`=0001), ALUWB (`reg_write`=1), FETCH.
- Load with `mem_ready` low for 3 cycles in MEMREAD → `mem_req`=1, `adr_src`=1 held 4 cycles; MEMWB `result_src`=01; total 8 cycles.
- BNE (funct3 001) with `zero`=0 → `pc_write`=1 in BRANCH; with `zero`=1 → `pc_write`=0; both return to FETCH.
- JALR (1100111) → JALRADR (`alu_src_a`=10, `alu_src_b`=01), JAL (`pc_write`=1, `result_src`=00), ALUWB (`reg_write`=1).
- SRAI (0010011, funct3 101, `funct7b5`=1) → `alu_control`=0111; ADDI with `funct7b5`=1 → `alu_control`=0000.
- Opcode 1111111 → TRAP, `halted`=1 for 10+ cycles. Assert `reset` mid-MEMWRITE wait → all outputs 0 immediately, FETCH after release.
